// File: rtl/key_debounce_encoder_pkg.sv
// Shared types and helpers for the key debounce/encoder block.
// Holds the encoder FSM state type, the counter/code width helpers and the
// lowest-set-bit priority encoder used to pick the accepted key.
package key_debounce_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } fsm_state_t;

    // Bits needed to count from 0 up to stable_cycles inclusive.
    function automatic int counter_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

    // Width of a binary key index, never narrower than one bit.
    function automatic int code_width(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce_encoder_if.sv
// Output bundle of the key debounce/encoder block.
// The encoder drives it through the master modport; display logic or any
// other consumer observes it through the slave modport.
interface key_debounce_encoder_if #(
    parameter int NUM_KEYS = 3
);

    localparam int CODE_W = key_debounce_pkg::code_width(NUM_KEYS);

    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] press_pulse;
    logic [NUM_KEYS-1:0] release_pulse;
    logic                key_event;
    logic [CODE_W-1:0]   key_code;
    logic                key_held;
    logic                multi_press;

    modport master (
        output key_state,
        output press_pulse,
        output release_pulse,
        output key_event,
        output key_code,
        output key_held,
        output multi_press
    );

    modport slave (
        input key_state,
        input press_pulse,
        input release_pulse,
        input key_event,
        input key_code,
        input key_held,
        input multi_press
    );

endinterface

// File: rtl/key_debounce_encoder_debounce_channel.sv
// One debounced key channel: two-flop synchroniser, stability counter that
// flips the debounced level only after STABLE_CYCLES consecutive cycles of
// disagreement, and registered press/release edge pulses.
module debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_raw,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int               CNT_W    = counter_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_out;
    logic             state_prev;
    logic [CNT_W-1:0] count;

    // Bring the asynchronous key level into the clock domain.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= key_raw;
            sync_out  <= sync_meta;
        end
    end

    // Count consecutive disagreeing cycles; the last one flips the level.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            count     <= '0;
            key_state <= 1'b0;
        end else if (sync_out == key_state) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            count     <= '0;
            key_state <= ~key_state;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    // Edge pulses come from the debounced level versus its previous value.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_prev    <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_prev    <= key_state;
            press_pulse   <= key_state & ~state_prev;
            release_pulse <= ~key_state & state_prev;
        end
    end

endmodule

// File: rtl/key_debounce_encoder.sv
// N-key push-button front end: per-key debounce channels feeding a
// hold/priority encoder that emits one key event per accepted press.
// Optional build macro KEY_DEBOUNCE_AUTO_REPEAT_EN adds a repeat timer that
// re-fires key_event while the accepted key stays held.
module key_debounce_encoder
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS      = 3,
    parameter int STABLE_CYCLES = 4,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 20
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NUM_KEYS-1:0]   key_raw,
    key_debounce_encoder_if.master bus
);

    localparam int CODE_W = code_width(NUM_KEYS);

    if (NUM_KEYS < 1 || NUM_KEYS > 16 || STABLE_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("key_debounce_encoder: parameter out of range");
    end

    logic [NUM_KEYS-1:0] state_vec;
    logic [NUM_KEYS-1:0] press_vec;
    logic [NUM_KEYS-1:0] release_vec;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .sys_clk      (sys_clk),
            .sys_rst      (sys_rst),
            .key_raw      (key_raw[gi]),
            .key_state    (state_vec[gi]),
            .press_pulse  (press_vec[gi]),
            .release_pulse(release_vec[gi])
        );
    end

    fsm_state_t          state;
    fsm_state_t          state_next;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_next;
    logic                event_q;
    logic                event_next;
    logic                multi_q;
    logic                multi_next;
    logic [3:0]          lowest_idx;
    logic [NUM_KEYS-1:0] held_mask;
    logic                held_release;
    logic                other_press;
    logic                repeat_fire;

    assign lowest_idx   = lowest_set(16'(press_vec));
    assign held_mask    = NUM_KEYS'(1) << code_q;
    assign held_release = |(release_vec & held_mask);
    assign other_press  = |(press_vec & ~held_mask);

`ifdef KEY_DEBOUNCE_AUTO_REPEAT_EN
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [TMR_W-1:0] timer;
    logic             repeating;

    assign repeat_fire = (state == HELD) &&
                         (repeating ? (timer == TMR_W'(REPEAT_PERIOD - 1))
                                    : (timer == TMR_W'(REPEAT_DELAY - 1)));

    // Repeat timer: first interval is the delay, later ones the period.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timer     <= '0;
            repeating <= 1'b0;
        end else if (state != HELD || held_release) begin
            timer     <= '0;
            repeating <= 1'b0;
        end else if (repeat_fire) begin
            timer     <= '0;
            repeating <= 1'b1;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    // Encoder state, latched key code, event pulse and multi-press flag.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            code_q  <= '0;
            event_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            state   <= state_next;
            code_q  <= code_next;
            event_q <= event_next;
            multi_q <= multi_next;
        end
    end

    // Accept the lowest pressed key when idle; track it until it releases.
    always_comb begin
        state_next = state;
        code_next  = code_q;
        event_next = 1'b0;
        multi_next = multi_q;
        case (state)
            IDLE: begin
                if (|press_vec) begin
                    code_next  = CODE_W'(lowest_idx);
                    event_next = 1'b1;
                    multi_next = 1'b0;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (held_release) begin
                    multi_next = 1'b0;
                    state_next = IDLE;
                end else begin
                    if (other_press) begin
                        multi_next = 1'b1;
                    end
                    if (repeat_fire) begin
                        event_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.key_state     = state_vec;
    assign bus.press_pulse   = press_vec;
    assign bus.release_pulse = release_vec;
    assign bus.key_event     = event_q;
    assign bus.key_code      = code_q;
    assign bus.key_held      = (state == HELD);
    assign bus.multi_press   = multi_q;

endmodule
